// File: rtl/execute_stage_v2.sv
// execute_stage_v2 - RV32I-style execute stage.
//   Holds the ID/EX pipeline register (sync reset, flush, stall), forwards
//   E-stage operands, runs the 4-bit ALU op set, resolves branches and
//   JAL/JALR, and optionally runs an iterative shift-add multiplier.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush, stall          bubble / hold requests for ID/EX
//   *D                    decode-stage controls, data and register indices
//   ForwardAE/BE          forward selects (00/11 RDxE, 01 ResultW, 10 ALUResultM)
//   ALUResultM, ResultW   forwarding sources
//   *E                    execute-stage outputs towards memory stage
//   BusyE                 multiply in progress: stall F/D/E, bubble M
module execute_stage_v2 #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned MUL_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              JALRD,
   input  logic              ALUSrcD,
   input  logic              MulD,
   input  logic [1:0]        ResultSrcD,
   input  logic [2:0]        BranchTypeD,
   input  logic [3:0]        ALUControlD,
   input  logic [WIDTH-1:0]  RD1D,
   input  logic [WIDTH-1:0]  RD2D,
   input  logic [WIDTH-1:0]  PCD,
   input  logic [WIDTH-1:0]  ImmExtD,
   input  logic [WIDTH-1:0]  PCPlus4D,
   input  logic [ADDR_W-1:0] Rs1D,
   input  logic [ADDR_W-1:0] Rs2D,
   input  logic [ADDR_W-1:0] RdD,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [WIDTH-1:0]  ALUResultM,
   input  logic [WIDTH-1:0]  ResultW,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              PCSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [WIDTH-1:0]  ALUResultE,
   output logic [WIDTH-1:0]  WriteDataE,
   output logic [WIDTH-1:0]  PCTargetE,
   output logic [WIDTH-1:0]  PCPlus4E,
   output logic [ADDR_W-1:0] RdE,
   output logic [ADDR_W-1:0] Rs1E,
   output logic [ADDR_W-1:0] Rs2E,
   output logic              BusyE
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;

   typedef struct packed {
      logic              reg_write;
      logic              mem_write;
      logic              jump;
      logic              branch;
      logic              jalr;
      logic              alu_src;
      logic              mul;
      logic [1:0]        result_src;
      logic [2:0]        branch_type;
      logic [3:0]        alu_control;
      logic [WIDTH-1:0]  rd1;
      logic [WIDTH-1:0]  rd2;
      logic [WIDTH-1:0]  pc;
      logic [WIDTH-1:0]  imm_ext;
      logic [WIDTH-1:0]  pc_plus4;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic [ADDR_W-1:0] rd;
   } idex_t;

   idex_t            idex_q, idex_d;
   mstate_e          mstate_q, mstate_d;
   logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;

   logic             busy;
   logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res, jalr_sum;
   logic [SHW-1:0]   shamt;
   logic             taken;

   // Busy covers the IDLE cycle that latches operands plus every RUN step.
   always_comb begin
      busy = 1'b0;
      if (MUL_EN != 0)
         busy = ((mstate_q == M_IDLE) && idex_q.mul) || (mstate_q == M_RUN);
   end

   always_comb begin
      idex_d = idex_q;
      if (!(stall || busy)) begin
         if (flush) begin
            idex_d = '0;
         end else begin
            idex_d.reg_write   = RegWriteD;
            idex_d.mem_write   = MemWriteD;
            idex_d.jump        = JumpD;
            idex_d.branch      = BranchD;
            idex_d.jalr        = JALRD;
            idex_d.alu_src     = ALUSrcD;
            idex_d.mul         = MulD;
            idex_d.result_src  = ResultSrcD;
            idex_d.branch_type = BranchTypeD;
            idex_d.alu_control = ALUControlD;
            idex_d.rd1         = RD1D;
            idex_d.rd2         = RD2D;
            idex_d.pc          = PCD;
            idex_d.imm_ext     = ImmExtD;
            idex_d.pc_plus4    = PCPlus4D;
            idex_d.rs1         = Rs1D;
            idex_d.rs2         = Rs2D;
            idex_d.rd          = RdD;
         end
      end
   end

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = idex_q.rd1;
      endcase
      case (ForwardBE)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = ALUResultM;
         default: fwd_b = idex_q.rd2;
      endcase
      src_b = idex_q.alu_src ? idex_q.imm_ext : fwd_b;
   end

   assign shamt = src_b[SHW-1:0];

   always_comb begin
      case (idex_q.alu_control)
         4'd0:    alu_res = src_a + src_b;
         4'd1:    alu_res = src_a - src_b;
         4'd2:    alu_res = src_a & src_b;
         4'd3:    alu_res = src_a | src_b;
         4'd4:    alu_res = src_a ^ src_b;
         4'd5:    alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         4'd6:    alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         4'd7:    alu_res = src_a << shamt;
         4'd8:    alu_res = src_a >> shamt;
         4'd9:    alu_res = $unsigned($signed(src_a) >>> shamt);
         4'd10:   alu_res = src_b;
         default: alu_res = '0;
      endcase
   end

   // Branches always compare against the forwarded register value.
   always_comb begin
      case (idex_q.branch_type)
         3'b000:  taken = (src_a == fwd_b);
         3'b001:  taken = (src_a != fwd_b);
         3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
         3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
         3'b110:  taken = (src_a <  fwd_b);
         3'b111:  taken = (src_a >= fwd_b);
         default: taken = 1'b0;
      endcase
   end

   assign jalr_sum = src_a + idex_q.imm_ext;

   // Shift-add multiplier: operands are private copies taken at start.
   always_comb begin
      mstate_d = mstate_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (!stall) begin
         case (mstate_q)
            M_IDLE: begin
               if ((MUL_EN != 0) && idex_q.mul) begin
                  ma_d     = src_a;
                  mb_d     = fwd_b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  mstate_d = M_RUN;
               end
            end
            M_RUN: begin
               if (mb_q[0])
                  acc_d = acc_q + ma_q;
               ma_d  = ma_q << 1;
               mb_d  = mb_q >> 1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == SHW'(WIDTH - 1))
                  mstate_d = M_DONE;
            end
            default: mstate_d = M_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q   <= '0;
         mstate_q <= M_IDLE;
         ma_q     <= '0;
         mb_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         idex_q   <= idex_d;
         mstate_q <= mstate_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign BusyE      = busy;
   assign RegWriteE  = idex_q.reg_write & ~busy;
   assign MemWriteE  = idex_q.mem_write & ~busy;
   assign PCSrcE     = ~busy & (idex_q.jump | (idex_q.branch & taken));
   assign ResultSrcE = idex_q.result_src;
   assign ALUResultE = (mstate_q == M_DONE) ? acc_q : alu_res;
   assign WriteDataE = fwd_b;
   assign PCTargetE  = idex_q.jalr ? {jalr_sum[WIDTH-1:1], 1'b0}
                                   : (idex_q.pc + idex_q.imm_ext);
   assign PCPlus4E   = idex_q.pc_plus4;
   assign RdE        = idex_q.rd;
   assign Rs1E       = idex_q.rs1;
   assign Rs2E       = idex_q.rs2;

endmodule

// File: tb/tb_execute_stage_v2.sv
// tb_execute_stage_v2 - directed scoreboard bench for execute_stage_v2
// (WIDTH=32, ADDR_W=5, MUL_EN=1). Expected E-stage results are pushed when
// an instruction is driven into decode and popped once it sits in E.
module tb_execute_stage_v2;

   logic        clk = 1'b0;
   logic        rst, flush, stall;
   logic        RegWriteD, MemWriteD, JumpD, BranchD, JALRD, ALUSrcD, MulD;
   logic [1:0]  ResultSrcD;
   logic [2:0]  BranchTypeD;
   logic [3:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUResultM, ResultW;
   logic        RegWriteE, MemWriteE, PCSrcE;
   logic [1:0]  ResultSrcE;
   logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
   logic [4:0]  RdE, Rs1E, Rs2E;
   logic        BusyE;

   execute_stage_v2 #(.WIDTH(32), .ADDR_W(5), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
      .BranchD(BranchD), .JALRD(JALRD), .ALUSrcD(ALUSrcD), .MulD(MulD),
      .ResultSrcD(ResultSrcD), .BranchTypeD(BranchTypeD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
      .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
      .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .BusyE(BusyE)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] alu, wd, tgt, pcp4;
      logic        pcsrc, regw, memw;
      logic [1:0]  rs;
      logic [4:0]  rd, rs1;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   errors = 0;
   int   checks = 0;
   int   n;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:  r = (a < b) ? 32'd1 : 32'd0;
         4'd7:  r = a << b[4:0];
         4'd8:  r = a >> b[4:0];
         4'd9:  r = $unsigned($signed(a) >>> b[4:0]);
         4'd10: r = b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic br_ref(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
      case (t)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return $signed(a) < $signed(b);
         3'b101: return $signed(a) >= $signed(b);
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic clear_inputs();
      {RegWriteD, MemWriteD, JumpD, BranchD, JALRD, ALUSrcD, MulD} = '0;
      ResultSrcD = '0; BranchTypeD = '0; ALUControlD = '0;
      RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
      Rs1D = '0; Rs2D = '0; RdD = '0;
      ForwardAE = '0; ForwardBE = '0; ALUResultM = '0; ResultW = '0;
   endtask

   // Drives one instruction into decode (forward selects/sources are held
   // until the next issue, so they apply while it sits in E) and records
   // the result it must produce there.
   task automatic issue(input string tag, input logic [3:0] op, input logic alusrc,
                        input logic br, input logic jmp, input logic jalr, input logic mul,
                        input logic regw, input logic memw, input logic [2:0] bt,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] alum, input logic [31:0] resw, input logic [4:0] rd);
      exp_t e;
      logic [31:0] a, bv, sbv;
      ALUControlD = op; ALUSrcD = alusrc; BranchD = br; JumpD = jmp; JALRD = jalr;
      MulD = mul; RegWriteD = regw; MemWriteD = memw; BranchTypeD = bt;
      RD1D = rd1; RD2D = rd2; PCD = pc; ImmExtD = imm; PCPlus4D = pc + 32'd4;
      RdD = rd; Rs1D = rd + 5'd1; Rs2D = rd + 5'd2; ResultSrcD = rd[1:0];
      ForwardAE = fa; ForwardBE = fb; ALUResultM = alum; ResultW = resw;
      a   = (fa == 2'b01) ? resw : (fa == 2'b10) ? alum : rd1;
      bv  = (fb == 2'b01) ? resw : (fb == 2'b10) ? alum : rd2;
      sbv = alusrc ? imm : bv;
      e.tag   = tag;
      e.alu   = mul ? a * bv : alu_ref(op, a, sbv);
      e.wd    = bv;
      e.tgt   = jalr ? ((a + imm) & ~32'd1) : (pc + imm);
      e.pcp4  = pc + 32'd4;
      e.pcsrc = jmp | (br & br_ref(bt, a, bv));
      e.regw  = regw;
      e.memw  = memw;
      e.rs    = rd[1:0];
      e.rd    = rd;
      e.rs1   = rd + 5'd1;
      sb.push_back(e);
   endtask

   task automatic check_e();
      exp_t e;
      chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({e.tag, ".alu"},   {32'd0, ALUResultE}, {32'd0, e.alu});
      chk({e.tag, ".wd"},    {32'd0, WriteDataE}, {32'd0, e.wd});
      chk({e.tag, ".tgt"},   {32'd0, PCTargetE},  {32'd0, e.tgt});
      chk({e.tag, ".pcp4"},  {32'd0, PCPlus4E},   {32'd0, e.pcp4});
      chk({e.tag, ".ctl"},   {53'd0, PCSrcE, RegWriteE, MemWriteE, ResultSrcE, BusyE, RdE},
                             {53'd0, e.pcsrc, e.regw, e.memw, e.rs, 1'b0, e.rd});
      chk({e.tag, ".rs1"},   {59'd0, Rs1E}, {59'd0, e.rs1});
      last = e;
   endtask

   // Ticks through the busy window of a multiply; M must see bubbles and no
   // redirect. The M-stage forward source is changed right after operand
   // latch to show the product ignores it.
   task automatic mul_wait(input int fl_on, input int fl_off, output int cnt);
      cnt = 0;
      while (BusyE === 1'b1 && cnt < 100) begin
         chk("mul_bubble", {61'd0, RegWriteE, MemWriteE, PCSrcE}, 64'd0);
         cnt++;
         flush = (cnt >= fl_on) && (cnt < fl_off);
         tick();
         if (cnt == 1) ALUResultM = ALUResultM + 32'd55;
      end
      flush = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      tick(); tick();
      chk("rst_ctl",  {43'd0, RegWriteE, MemWriteE, PCSrcE, ResultSrcE, BusyE, RdE, Rs1E, Rs2E}, 64'd0);
      chk("rst_d0",   {ALUResultE, WriteDataE}, 64'd0);
      chk("rst_d1",   {PCTargetE, PCPlus4E}, 64'd0);
      rst = 1'b0;

      // Forwarding: ALUResultM into A, ResultW into B, immediate on SrcB.
      issue("fwd_add", 4'd0, 1, 0, 0, 0, 0, 1, 0, 3'b000, 32'd5, 32'd9, 32'h100, 32'd3,
            2'b10, 2'b01, 32'd100, 32'd77, 5'd4);
      tick(); check_e();
      issue("fwd_sub", 4'd1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'd1, 32'd2, 32'h104, 32'd0,
            2'b01, 2'b10, 32'd40, 32'd500, 5'd5);
      tick(); check_e();
      issue("add_wrap", 4'd0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h108, 32'd0,
            2'b00, 2'b11, 32'd0, 32'd0, 5'd6);
      tick(); check_e();

      // Every ALU op on one operand pair; B=0x24 exercises shift-amount masking.
      for (int op = 0; op < 16; op++) begin
         issue($sformatf("alu%0d", op), 4'(op), 0, 0, 0, 0, 0, 1, 0, 3'b000,
               32'h8000_00F5, 32'h0000_0024, 32'h200, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd7);
         tick(); check_e();
      end

      // Branches: compare uses forwarded B, immediate only feeds the target.
      issue("blt",  4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h40, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("bltu", 4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h40, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("bge",  4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h1010, 32'h20, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("bgeu", 4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h1010, 32'h20, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("beq",  4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b000, 32'h55, 32'h55, 32'h2000, 32'd7, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("bne",  4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b001, 32'h55, 32'h55, 32'h2000, 32'd7, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("b010", 4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 32'h55, 32'h55, 32'h2000, 32'd7, 2'b00, 2'b00, 0, 0, 5'd0);
      tick(); check_e();
      issue("beq_fwd", 4'd0, 1, 1, 0, 0, 0, 0, 0, 3'b000, 32'h1, 32'h2, 32'h2100, 32'd8, 2'b10, 2'b01, 32'h99, 32'h99, 5'd0);
      tick(); check_e();

      // JALR target clears bit 0.
      issue("jalr", 4'd0, 1, 0, 1, 1, 0, 1, 0, 3'b000, 32'h1001, 32'd0, 32'h400, 32'd4, 2'b00, 2'b00, 0, 0, 5'd1);
      tick(); check_e();

      // Multiply 7 x 0xFFFFFFFF, A operand forwarded from M.
      issue("mul1", 4'd0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 32'd0, 32'hFFFF_FFFF, 32'h500, 32'd0,
            2'b10, 2'b00, 32'd7, 32'd0, 5'd10);
      tick();
      mul_wait(0, 0, n);
      chk("mul1_busy_cycles", 64'(n), 64'd33);
      check_e();
      issue("after_mul", 4'd0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'd1, 32'd2, 32'h504, 32'd0,
            2'b00, 2'b00, 0, 0, 5'd11);
      tick(); check_e();

      // Plain flush clears all E controls.
      issue("pre_flush", 4'd0, 0, 0, 1, 0, 0, 1, 1, 3'b000, 32'd3, 32'd4, 32'h600, 32'h10,
            2'b00, 2'b00, 0, 0, 5'd9);
      tick(); check_e();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ctl",  {55'd0, RegWriteE, MemWriteE, PCSrcE, ResultSrcE, RdE}, 64'd0);
      chk("flush_data", {ALUResultE, PCPlus4E}, 64'd0);

      // Stall beats flush: E keeps its contents.
      issue("hold", 4'd3, 0, 0, 0, 0, 0, 1, 0, 3'b000, 32'hF0, 32'h0F, 32'h700, 32'd8,
            2'b00, 2'b00, 0, 0, 5'd12);
      tick(); check_e();
      RD1D = 32'hAAAA; RdD = 5'd3; RegWriteD = 1'b0; PCPlus4D = 32'h1234;
      flush = 1'b1; stall = 1'b1;
      last.tag = "hold_stall";
      sb.push_back(last);
      tick(); check_e();
      flush = 1'b0; stall = 1'b0;

      // Flush raised mid-multiply is ignored.
      issue("mul_flush", 4'd0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 32'd13, 32'd11, 32'h800, 32'd0,
            2'b00, 2'b00, 0, 0, 5'd13);
      tick();
      mul_wait(5, 10, n);
      chk("mul_flush_busy_cycles", 64'(n), 64'd33);
      check_e();

      // Reset in RUN cycle 10 of a multiply.
      issue("mul_rst", 4'd0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 32'd3, 32'd5, 32'h900, 32'd0,
            2'b00, 2'b00, 0, 0, 5'd14);
      tick();
      n = 0;
      while (BusyE === 1'b1 && n < 10) begin
         n++;
         tick();
      end
      chk("rst_pre_busy", {63'd0, BusyE}, 64'd1);
      void'(sb.pop_front());
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmul_ctl", {43'd0, RegWriteE, MemWriteE, PCSrcE, ResultSrcE, BusyE, RdE, Rs1E, Rs2E}, 64'd0);
      chk("rstmul_d0",  {ALUResultE, WriteDataE}, 64'd0);
      chk("rstmul_d1",  {PCTargetE, PCPlus4E}, 64'd0);

      issue("mul_post_rst", 4'd0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 32'h1234_5678, 32'h10, 32'hA00, 32'd0,
            2'b00, 2'b00, 0, 0, 5'd15);
      tick();
      mul_wait(0, 0, n);
      chk("mul_post_rst_busy_cycles", 64'(n), 64'd33);
      check_e();
      clear_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_stage_v2.md
Name: execute_stage_v2

Overview:
- Parametrised successor of the execute stage. It contains the ID/EX pipeline register with synchronous reset, flush and stall, and E-stage operand forwarding.
- It executes a 4-bit ALU op set, resolves all six RV32I branch conditions plus JAL/JALR, and runs an optional iterative multiplier (MUL, low word).
- It sits between decode and memory stages. BusyE is its stall request to the hazard unit.

Parameters:
- WIDTH, 32, datapath width (power of two, ≥8)
- ADDR_W, 5, register index width
- MUL_EN, 1, 1 = multiplier present; 0 = MulD ignored, BusyE tied 0

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  load bubble into ID/EX
- stall  in  1  hold ID/EX and multiplier FSM
- RegWriteD, MemWriteD, JumpD, BranchD, JALRD, ALUSrcD, MulD  in  1 each  decode controls
- ResultSrcD  in  2  result select
- BranchTypeD  in  3  funct3 of branch
- ALUControlD  in  4  ALU op
- RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  WIDTH each  decode data
- Rs1D, Rs2D, RdD  in  ADDR_W each  register indices
- ForwardAE, ForwardBE  in  2 each  forward selects from hazard unit
- ALUResultM, ResultW  in  WIDTH each  forwarding sources
- RegWriteE, MemWriteE, PCSrcE  out  1 each
- ResultSrcE  out  2
- ALUResultE, WriteDataE, PCTargetE, PCPlus4E  out  WIDTH each
- RdE, Rs1E, Rs2E  out  ADDR_W each
- BusyE  out  1  multiply in progress; stall F/D/E, bubble M

Behaviour:
- ID/EX register: one-cycle latency. Priority on each edge is: rst > (stall | BusyE) hold > flush > load.
  - rst or flush clears every control and data field to 0.
  - Flush is ignored while BusyE=1 or stall=1.
- Reset values: all outputs 0; FSM IDLE.
- Forwarding (combinational) for SrcAE and the forwarded B value:
  - 00 = RDxE; 01 = ResultW; 10 = ALUResultM; 11 = RDxE.
- WriteDataE = forwarded B. SrcBE = ALUSrcE ? ImmExtE : forwarded B.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed), 6 SLTU
  - 7 SLL, 8 SRL, 9 SRA; shift amount is SrcBE[log2(WIDTH)-1:0]
  - 10 PASSB (LUI)
  - 11-15 give result 0
  - Arithmetic wraps modulo 2^WIDTH.
- Branch taken, by BranchTypeE:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
  - 010/011 never taken
  - Compare SrcAE against forwarded B, never against the immediate.
- PCSrcE = JumpE | (BranchE & taken), forced to 0 while BusyE=1.
- PCTargetE = JALRE ? ((SrcAE + ImmExtE) & ~1) : (PCE + ImmExtE).
- Multiplier FSM, used when MUL_EN=1 and MulE=1. States are IDLE, RUN and DONE.
  - IDLE with MulE=1: BusyE=1 combinationally. Next edge latches SrcAE and the forwarded B into private registers, clears the accumulator and counter, and goes to RUN.
  - RUN: one shift-add step per cycle, LSB first. After WIDTH steps (counter = WIDTH-1) go to DONE. BusyE=1.
  - DONE: BusyE=0 and ALUResultE = low WIDTH bits of the product. The ID/EX register loads normally on the next edge, and the FSM returns to IDLE.
  - Total BusyE-high cycles: WIDTH+1. The instruction occupies E for WIDTH+2 cycles.
  - stall=1 freezes the FSM in its current state.
- While BusyE=1, RegWriteE and MemWriteE are output as 0, so M receives bubbles. ALUResultE is don't-care during this time.
- rst mid-multiply: FSM goes to IDLE, ID/EX is cleared, and BusyE=0 in the following cycle.
- Operands are latched at multiply start, so later changes on ALUResultM/ResultW during RUN do not affect the product.
- MUL_EN=0: MulE is ignored and the instruction executes as the plain ALU op.

Test Plan:
- Forwarding: load ADD with RD1D=5, ForwardAE=10, ALUResultM=100, ALUSrcD=1, ImmExtD=3 -> ALUResultE=103 one cycle after load.
- Branches: BLT with SrcA=-1 (0xFFFFFFFF), B=1 -> PCSrcE=1 and PCTargetE=PCE+ImmExtE. The same operands with BLTU -> PCSrcE=0. BEQ with equal operands -> PCSrcE=1.
- JALR: SrcA=0x1001, ImmExtE=4 -> PCTargetE=0x1004, PCSrcE=1, PCPlus4E equals the loaded PCPlus4D.
- Multiply: MUL with 7 × 0xFFFFFFFF (WIDTH=32) -> BusyE high 33 cycles, RegWriteE=0 during that time; DONE cycle gives ALUResultE=0xFFFFFFF9 and RegWriteE=1. The next instruction loads on the following edge.
- Flush/stall priority: flush=1 with stall=0 -> all E controls 0 next cycle. flush=1 and stall=1 together -> register contents unchanged. flush during a multiply -> ignored, product still correct.
- Reset: assert rst in RUN cycle 10 of a multiply -> next cycle BusyE=0 and all outputs 0. A MUL issued afterwards completes with the correct product.
